// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU-side memory responder.
package cpu_mem_pkg;
    localparam int WORD_W          = 32;
    localparam int DEF_DEPTH_LOG2  = 8;
    localparam int DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;
endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read through a single shared index.
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [WORD_W-1:0]     i_wdata,
    output logic [WORD_W-1:0]     o_rdata
);
    logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states.
// Optional MEM_ALIGN_CHECK_EN flags misaligned accesses via mem_err.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);
    mem_state_t            r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [WORD_W-1:0]     r_wdata;
    logic                  r_is_wr;
    logic                  r_misal;
    logic                  r_err;

    logic                  w_req;
    logic                  w_in_misal;
    logic [DEPTH_LOG2-1:0] w_in_idx;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_go_resp;
    logic                  w_nxt_wr;
    logic                  w_nxt_misal;
    logic                  w_we;
    logic [WORD_W-1:0]     w_rd;
    logic                  w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_in_idx = addr[DEPTH_LOG2+1:2];
    assign w_unused = &{1'b0, addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign w_in_misal = |addr[1:0];
`else
    assign w_in_misal = 1'b0;
`endif

    // In IDLE the array is indexed straight from the bus so a zero-wait read
    // can load rdata on the capture edge; afterwards the captured index rules.
    assign w_idx       = (r_state == IDLE) ? w_in_idx : r_idx;
    assign w_nxt_wr    = (r_state == IDLE) ? mem_write : r_is_wr;
    assign w_nxt_misal = (r_state == IDLE) ? w_in_misal : r_misal;
    assign w_go_resp   = ((r_state == IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == 4'd1));
    assign w_we        = (r_state == RESP) && r_is_wr && !r_misal;
    assign mem_err     = r_err;

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_misal   <= 1'b0;
            r_err     <= 1'b0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            r_err     <= 1'b0;
            // Response outputs are registered on the edge entering RESP.
            if (w_go_resp) begin
                mem_ready <= 1'b1;
                r_err     <= w_nxt_misal;
                if (!w_nxt_wr) rdata <= w_nxt_misal ? '0 : w_rd;
            end
            case (r_state)
                IDLE: if (w_req) begin
                    r_idx    <= w_in_idx;
                    r_wdata  <= wdata;
                    r_is_wr  <= mem_write;
                    r_misal  <= w_in_misal;
                    r_cnt    <= 4'(WAIT_CYCLES);
                    mem_busy <= 1'b1;
                    r_state  <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= RESP;
                end
                RESP: begin
                    mem_busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states) share one
// request bus and are checked every cycle against a transaction-level model.
module tb_mem_responder;
    localparam int N     = 3;
    localparam int DEPTH = 256;
    localparam int WC [N]      = '{0, 1, 3};
    localparam int LAT_LIT [N] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata [N];
    logic        ready [N];
    logic        busy  [N];
    logic        err   [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata[0]), .mem_ready(ready[0]),
        .mem_busy(busy[0]), .mem_err(err[0]));
    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata[1]), .mem_ready(ready[1]),
        .mem_busy(busy[1]), .mem_err(err[1]));
    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata[2]), .mem_ready(ready[2]),
        .mem_busy(busy[2]), .mem_err(err[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit misal(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction model: one access per instance, with capture edge and end edge.
    logic [31:0] mdl [N][DEPTH];
    bit          pend [N];
    int          endc [N];
    bit          m_wr [N];
    bit          m_mis [N];
    int          m_idx [N];
    logic [31:0] m_wd [N];
    logic [31:0] m_last [N];
    int          ecnt = 0;

    initial for (int k = 0; k < N; k++) begin
        pend[k] = 0; m_last[k] = '0;
    end

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                pend[k] = 0;
                m_last[k] = '0;
            end else if (pend[k]) begin
                if (ecnt == endc[k] + 1) begin
                    if (m_wr[k] && !m_mis[k]) mdl[k][m_idx[k]] = m_wd[k];
                    pend[k] = 0;
                end
            end else if (mem_read || mem_write) begin
                pend[k]  = 1;
                endc[k]  = ecnt + WC[k];
                m_wr[k]  = mem_write;
                m_idx[k] = int'(addr >> 2) % DEPTH;
                m_wd[k]  = wdata;
                m_mis[k] = misal(addr);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            bit rdy_e;
            rdy_e = pend[k] && (ecnt == endc[k]);
            if (rdy_e && !m_wr[k]) m_last[k] = m_mis[k] ? 32'h0 : mdl[k][m_idx[k]];
            chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(rdy_e));
            chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(pend[k]));
            chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(rdy_e && m_mis[k]));
            chk($sformatf("rdata[%0d]", k), rdata[k], m_last[k]);
        end
    end

    // Per-access observations for literal checks.
    int          lat [N];
    int          nrdy [N];
    logic [31:0] rd_at [N];
    logic        err_at [N];

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit any_busy;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int k = 0; k < N; k++) begin
            lat[k] = -1; nrdy[k] = 0; rd_at[k] = 'x; err_at[k] = 1'bx;
        end
        for (int off = 1; off <= 12; off++) begin
            @(negedge clk);
            any_busy = 0;
            for (int k = 0; k < N; k++) begin
                if (ready[k]) begin
                    if (lat[k] < 0) lat[k] = off;
                    nrdy[k]++;
                    rd_at[k] = rdata[k];
                    err_at[k] = err[k];
                end
                if (busy[k]) any_busy = 1;
            end
            // Scramble the bus mid-access; request strobes stay low.
            mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
            if (!any_busy) return;
        end
        chk("req_timeout", 32'(any_busy), 32'd0);
    endtask

    task automatic chk_lat(input string nm);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_lat[%0d]", nm, k), 32'(lat[k]), 32'(LAT_LIT[k]));
            chk($sformatf("%s_npulse[%0d]", nm, k), 32'(nrdy[k]), 32'd1);
        end
    endtask

    initial begin
        int n_rdy;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
            chk($sformatf("rst_ready[%0d]", k), 32'(ready[k]), 32'h0);
            chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) req(0, 1, 32'(i * 4), 32'h1000_0000 + 32'(i));

        req(0, 1, 32'h10, 32'hDEADBEEF);
        chk_lat("wr10");
        req(1, 0, 32'h10, 32'h0);
        chk_lat("rd10");
        for (int k = 0; k < N; k++) chk($sformatf("rd10_data[%0d]", k), rd_at[k], 32'hDEADBEEF);

        req(1, 0, 32'h0, 32'h0);
        chk_lat("rd0");
        for (int k = 0; k < N; k++) chk($sformatf("rd0_data[%0d]", k), rd_at[k], 32'h1000_0000);

        req(0, 1, 32'h400, 32'h11111111);
        req(1, 0, 32'h000, 32'h0);
        for (int k = 0; k < N; k++) chk($sformatf("wrap_data[%0d]", k), rd_at[k], 32'h11111111);

        req(1, 1, 32'h8, 32'hA5A5A5A5);
        for (int k = 0; k < N; k++) chk($sformatf("both_rdata_held[%0d]", k), rd_at[k], 32'h11111111);
        req(1, 0, 32'h8, 32'h0);
        for (int k = 0; k < N; k++) chk($sformatf("both_data[%0d]", k), rd_at[k], 32'hA5A5A5A5);

        // Reset during the wait states of a write.
        @(negedge clk);
        mem_write = 1; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        mem_write = 0; addr = '0; wdata = '0;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("abort_rdata[%0d]", k), rdata[k], 32'h0);
            chk($sformatf("abort_ready[%0d]", k), 32'(ready[k]), 32'h0);
            chk($sformatf("abort_busy[%0d]", k), 32'(busy[k]), 32'h0);
            chk($sformatf("abort_err[%0d]", k), 32'(err[k]), 32'h0);
        end
        rst = 1'b0;
        n_rdy = 0;
        repeat (6) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (ready[k]) n_rdy++;
        end
        chk("abort_no_pulse", 32'(n_rdy), 32'd0);
        req(1, 0, 32'h20, 32'h0);
        for (int k = 0; k < N; k++) chk($sformatf("abort_kept[%0d]", k), rd_at[k], 32'h1000_0008);

        req(0, 1, 32'h13, 32'hCAFEF00D);
`ifdef MEM_ALIGN_CHECK_EN
        for (int k = 0; k < N; k++) chk($sformatf("mis_wr_err[%0d]", k), 32'(err_at[k]), 32'd1);
        req(1, 0, 32'h10, 32'h0);
        for (int k = 0; k < N; k++) chk($sformatf("mis_unchanged[%0d]", k), rd_at[k], 32'hDEADBEEF);
        req(1, 0, 32'h13, 32'h0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("mis_rd_err[%0d]", k), 32'(err_at[k]), 32'd1);
            chk($sformatf("mis_rd_zero[%0d]", k), rd_at[k], 32'h0);
        end
        chk_lat("mis_rd");
`else
        for (int k = 0; k < N; k++) chk($sformatf("noalign_err[%0d]", k), 32'(err_at[k]), 32'd0);
        req(1, 0, 32'h10, 32'h0);
        for (int k = 0; k < N; k++) chk($sformatf("noalign_data[%0d]", k), rd_at[k], 32'hCAFEF00D);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameters: DEPTH_LOG2, 8, word-array depth = 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter: WAIT_CYCLES, 1, wait states inserted before response (0..15).
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request from CPU control.
- mem_write  in  1  write request from CPU control.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high from request capture until and including the response cycle.
- mem_err  out  1  access fault, valid while mem_ready=1.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-005 In IDLE, when mem_read|mem_write is high at a rising edge, SHALL capture addr, wdata and the operation, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-006 If mem_read and mem_write are both high at capture, SHALL treat the access as a write.
REQ-007 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit down-counter loaded at capture, then go to RESP.
REQ-008 Latency: capture at edge N; mem_ready SHALL be high during cycle N+1+WAIT_CYCLES for exactly one cycle.
REQ-009 RESP SHALL assert mem_ready=1 and return to IDLE on the next edge; a new request SHALL NOT be captured in RESP.
REQ-010 Reads: rdata SHALL equal the word at the captured index during RESP and hold its value afterwards until the next read response.
REQ-011 Writes: the array word SHALL be updated at the edge ending RESP; rdata SHALL be unchanged.
REQ-012 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).
REQ-013 Request inputs SHALL be ignored outside IDLE; changing them mid-access SHALL NOT affect the access in progress.
REQ-014 mem_busy SHALL be high in WAIT and RESP and low in IDLE.

Reset
REQ-015 rst SHALL force IDLE, rdata=0, mem_ready=0, mem_busy=0, mem_err=0 and clear the counter.
REQ-016 Asserting rst mid-access SHALL abort the access with no array write and no mem_ready pulse.
REQ-017 Array contents SHALL NOT be reset.

Configuration
REQ-018 With MEM_ALIGN_CHECK_EN defined, a captured addr[1:0]!=0 SHALL produce mem_err=1 in RESP, suppress the write and force rdata=0; latency SHALL be unchanged.
REQ-019 Without MEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and mem_err SHALL be tied to 0.

Structure
REQ-020 A shared package cpu_mem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), the word width (32) and the default DEPTH_LOG2/WAIT_CYCLES constants.
REQ-021 The storage SHALL be a sub-module mem_array: synchronous write, combinational read, parameterised by DEPTH_LOG2.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_CYCLES=1 -> rdata=0xDEADBEEF, mem_ready in cycle N+2 for one cycle.
- WAIT_CYCLES=0: read 0x0 -> mem_ready at cycle N+1; WAIT_CYCLES=3 -> mem_ready at cycle N+4.
- DEPTH_LOG2=8: write 0x11111111 to 0x400, then read 0x000 -> 0x11111111 (wrap).
- mem_read and mem_write both high with wdata=0xA5A5A5A5 at 0x8 -> word 0x8 written; a later read returns 0xA5A5A5A5.
- rst pulsed in WAIT of a write of 0x12345678 to 0x20 -> no mem_ready pulse, word 0x20 keeps its old value, all outputs 0.
- MEM_ALIGN_CHECK_EN defined: write to 0x13 -> mem_err=1, rdata=0, array unchanged; macro undefined -> mem_err stays 0.
